// File: rtl/mult_rr_sched_pkg.sv
// mult_rr_sched_pkg: shared state encoding and requester ids for the round-robin multiplier scheduler
package mult_rr_sched_pkg;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    localparam logic ID_0 = 1'b0;
    localparam logic ID_1 = 1'b1;
    typedef enum logic [1:0] {IDLE = ST_IDLE, MUL = ST_MUL, DONE = ST_DONE} state_t;
endpackage

// File: rtl/mult_rr_sched_if.sv
// mult_rr_sched_if: requester, consumer and status signals of the shared multiplier
interface mult_rr_sched_if #(parameter int w = 4);
    logic req0, req1, ack, gnt0, gnt1, busy, done, res_id;
    logic [w-1:0] a0, b0, a1, b1;
    logic [2*w-1:0] res;
    modport master (output req0, a0, b0, req1, a1, b1, ack,
                    input gnt0, gnt1, busy, done, res_id, res);
    modport slave (input req0, a0, b0, req1, a1, b1, ack,
                   output gnt0, gnt1, busy, done, res_id, res);
endinterface

// File: rtl/mult_rr_sched_mult_pipe.sv
// mult_pipe: unsigned w x w product registered through LAT stages
module mult_pipe #(parameter int w = 4, parameter int LAT = 2) (
    input  logic           clk,
    input  logic           rst_b,
    input  logic [w-1:0]   a,
    input  logic [w-1:0]   b,
    output logic [2*w-1:0] p
);
    logic [2*w-1:0] st [LAT];
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            for (int i = 0; i < LAT; i++) st[i] <= '0;
        end else begin
            st[0] <= (2*w)'(a) * (2*w)'(b);
            for (int i = 1; i < LAT; i++) st[i] <= st[i-1];
        end
    end
    assign p = st[LAT-1];
endmodule

// File: rtl/mult_rr_sched.sv
// mult_rr_sched: round-robin arbiter sharing one LAT-cycle multiplier between two requesters
module mult_rr_sched import mult_rr_sched_pkg::*; #(parameter int w = 4, parameter int LAT = 2) (
    input logic           clk,
    input logic           rst_b,
    mult_rr_sched_if.slave bus
);
    localparam int CW = LAT > 1 ? $clog2(LAT) : 1;
    state_t state, nxt;
    logic rr, win, win_q, accept;
    logic [CW-1:0] cnt;
    logic [2*w-1:0] prod;
    assign accept = state == IDLE && (bus.req0 || bus.req1);
    // on contention the requester not served last wins; a lone requester always wins
    assign win = (bus.req0 && bus.req1) ? ~rr : bus.req1;
    assign bus.busy = state != IDLE;
    // the winner's product enters the pipe on the accepting edge and emerges LAT-1 edges later
    mult_pipe #(.w(w), .LAT(LAT)) u_pipe (
        .clk(clk),
        .rst_b(rst_b),
        .a(win ? bus.a1 : bus.a0),
        .b(win ? bus.b1 : bus.b0),
        .p(prod)
    );
    always_ff @(posedge clk) begin
        if (!rst_b) state <= IDLE;
        else state <= nxt;
    end
    always_comb begin
        nxt = state;
        nxt = accept ? MUL :
              (state == MUL && cnt == '0) ? DONE :
              (state == DONE && bus.ack) ? IDLE : state;
    end
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            rr <= ID_1;
            win_q <= ID_0;
            cnt <= '0;
            bus.gnt0 <= 1'b0;
            bus.gnt1 <= 1'b0;
            bus.done <= 1'b0;
            bus.res <= '0;
            bus.res_id <= ID_0;
        end else begin
            bus.gnt0 <= accept && win == ID_0;
            bus.gnt1 <= accept && win == ID_1;
            if (accept) begin
                rr <= win;
                win_q <= win;
                cnt <= CW'(LAT - 1);
            end else if (state == MUL) begin
                cnt <= cnt - 1'b1;
            end
            if (state == MUL && cnt == '0) begin
                bus.res <= prod;
                bus.res_id <= win_q;
                bus.done <= 1'b1;
            end else if (state == DONE && bus.ack) begin
                bus.done <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mult_rr_sched.sv
// tb_mult_rr_sched: directed scoreboard bench for mult_rr_sched (w=4/LAT=2 and w=6/LAT=3)
module tb_mult_rr_sched;
    logic clk = 1'b0;
    logic rst_b = 1'b0;
    int n_cmp = 0;
    int n_err = 0;
    int q4[$];
    int q6[$];
    logic seen4 = 1'b0, seen6 = 1'b0;
    logic [31:0] held4, held6;

    mult_rr_sched_if #(.w(4)) b4();
    mult_rr_sched_if #(.w(6)) b6();
    mult_rr_sched #(.w(4), .LAT(2)) u4 (.clk(clk), .rst_b(rst_b), .bus(b4));
    mult_rr_sched #(.w(6), .LAT(3)) u6 (.clk(clk), .rst_b(rst_b), .bus(b6));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic do_reset;
        rst_b = 1'b0;
        tick;
        tick;
        rst_b = 1'b1;
    endtask

    // waits for a grant, checks its owner, waits for done and acknowledges it
    task automatic run_one(input logic exp_id, input bit keep);
        int k;
        k = 0;
        while (!(b4.gnt0 || b4.gnt1) && k < 20) begin tick; k++; end
        chk("gnt_seen", 32'(b4.gnt0 | b4.gnt1), 1);
        chk("gnt_id", 32'(b4.gnt1), 32'(exp_id));
        if (!keep) begin
            if (b4.gnt0) b4.req0 = 1'b0;
            else b4.req1 = 1'b0;
        end
        k = 0;
        while (!b4.done && k < 20) begin tick; k++; end
        chk("done_seen", 32'(b4.done), 1);
        b4.ack = 1'b1;
        tick;
        b4.ack = 1'b0;
        chk("done_clr", 32'(b4.done), 0);
        chk("busy_clr", 32'(b4.busy), 0);
    endtask

    always @(negedge clk) begin
        int e;
        if (b4.done && !seen4) begin
            if (q4.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL res4_unexpected: got %0d expected no result", b4.res);
            end else begin
                e = q4.pop_front();
                chk("res4", 32'(b4.res), e & 32'hFFFF);
                chk("res4_id", 32'(b4.res_id), e >> 16);
            end
            held4 = 32'(b4.res);
        end else if (b4.done) begin
            chk("res4_hold", 32'(b4.res), held4);
        end
        seen4 = b4.done;
        if (b6.done && !seen6) begin
            if (q6.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL res6_unexpected: got %0d expected no result", b6.res);
            end else begin
                e = q6.pop_front();
                chk("res6", 32'(b6.res), e & 32'hFFFF);
                chk("res6_id", 32'(b6.res_id), e >> 16);
            end
            held6 = 32'(b6.res);
        end else if (b6.done) begin
            chk("res6_hold", 32'(b6.res), held6);
        end
        seen6 = b6.done;
    end

    initial begin
        {b4.req0, b4.req1, b4.ack, b4.a0, b4.b0, b4.a1, b4.b1} = '0;
        {b6.req0, b6.req1, b6.ack, b6.a0, b6.b0, b6.a1, b6.b1} = '0;
        // reset held while req0 is asserted
        b4.req0 = 1'b1; b4.a0 = 4'd5; b4.b0 = 4'd10;
        tick;
        tick;
        chk("rst_gnt0", 32'(b4.gnt0), 0);
        chk("rst_busy", 32'(b4.busy), 0);
        chk("rst_done", 32'(b4.done), 0);
        chk("rst_res", 32'(b4.res), 0);
        // single job 5x10
        q4.push_back(50);
        rst_b = 1'b1;
        tick;
        chk("single_gnt0", 32'(b4.gnt0), 1);
        chk("single_busy", 32'(b4.busy), 1);
        chk("single_done_e0", 32'(b4.done), 0);
        b4.req0 = 1'b0;
        tick;
        chk("single_gnt0_pulse", 32'(b4.gnt0), 0);
        chk("single_done_e1", 32'(b4.done), 0);
        tick;
        chk("single_done_e2", 32'(b4.done), 1);
        repeat (3) tick;
        chk("single_done_held", 32'(b4.done), 1);
        b4.ack = 1'b1;
        tick;
        b4.ack = 1'b0;
        chk("single_done_clr", 32'(b4.done), 0);
        chk("single_busy_clr", 32'(b4.busy), 0);
        // contention: 3x4 vs 15x15, then 2x2 vs 7x7
        do_reset;
        q4.push_back(12); q4.push_back((1 << 16) | 225);
        b4.req0 = 1'b1; b4.a0 = 4'd3; b4.b0 = 4'd4;
        b4.req1 = 1'b1; b4.a1 = 4'd15; b4.b1 = 4'd15;
        run_one(1'b0, 1'b0);
        run_one(1'b1, 1'b0);
        q4.push_back(4); q4.push_back((1 << 16) | 49);
        b4.req0 = 1'b1; b4.a0 = 4'd2; b4.b0 = 4'd2;
        b4.req1 = 1'b1; b4.a1 = 4'd7; b4.b1 = 4'd7;
        run_one(1'b0, 1'b0);
        run_one(1'b1, 1'b0);
        // lone requester 1 served back-to-back despite rr
        do_reset;
        q4.push_back((1 << 16) | 225); q4.push_back((1 << 16) | 14);
        b4.req1 = 1'b1; b4.a1 = 4'd15; b4.b1 = 4'd15;
        run_one(1'b1, 1'b1);
        b4.a1 = 4'd7; b4.b1 = 4'd2;
        run_one(1'b1, 1'b0);
        b4.ack = 1'b1;
        tick;
        b4.ack = 1'b0;
        chk("idle_ack_done", 32'(b4.done), 0);
        chk("idle_ack_busy", 32'(b4.busy), 0);
        chk("idle_ack_res", 32'(b4.res), 14);
        // abort during MUL
        b4.req0 = 1'b1; b4.a0 = 4'd13; b4.b0 = 4'd13;
        tick;
        chk("abort_gnt0", 32'(b4.gnt0), 1);
        b4.req0 = 1'b0;
        rst_b = 1'b0;
        tick;
        tick;
        rst_b = 1'b1;
        repeat (4) tick;
        chk("abort_done", 32'(b4.done), 0);
        chk("abort_res", 32'(b4.res), 0);
        chk("abort_busy", 32'(b4.busy), 0);
        q4.push_back(65);
        b4.req0 = 1'b1; b4.a0 = 4'd13; b4.b0 = 4'd5;
        run_one(1'b0, 1'b0);
        // w=6, LAT=3: 63x63
        q6.push_back((1 << 16) | 3969);
        b6.req1 = 1'b1; b6.a1 = 6'd63; b6.b1 = 6'd63;
        tick;
        chk("w6_gnt1", 32'(b6.gnt1), 1);
        b6.req1 = 1'b0;
        tick;
        chk("w6_done_e1", 32'(b6.done), 0);
        tick;
        chk("w6_done_e2", 32'(b6.done), 0);
        tick;
        chk("w6_done_e3", 32'(b6.done), 1);
        b6.ack = 1'b1;
        tick;
        b6.ack = 1'b0;
        chk("w6_done_clr", 32'(b6.done), 0);
        tick;
        chk("q4_empty", 32'(q4.size()), 0);
        chk("q6_empty", 32'(q6.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
